// File: rtl/text_ram_pkg.sv
// rtl/text_ram_pkg.sv - shared defaults, FSM states and grant codes for the text RAM arbiter
package text_ram_pkg;
    localparam int TEXT_AW = 10;
    localparam int TEXT_DW = 8;

    typedef enum logic {CLEAR, RUN} state_t;
    typedef enum logic [2:0] {G_NONE, G_DISP, G_WR, G_RD, G_CLR} grant_t;
endpackage

// File: rtl/text_ram_wfifo.sv
// rtl/text_ram_wfifo.sv - host write queue: DEPTH x W synchronous FIFO with full/empty/count
module text_ram_wfifo #(
    parameter int DEPTH = 4,
    parameter int W     = 18
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);
endmodule

// File: rtl/text_ram_arbiter.sv
// rtl/text_ram_arbiter.sv - single-port text RAM arbiter: display priority, queued host writes, starvation slot
// Optional post-reset clear sweep enabled by TEXT_RAM_CLEAR_EN.
module text_ram_arbiter
    import text_ram_pkg::*;
#(
    parameter int            AW           = TEXT_AW,
    parameter int            DW           = TEXT_DW,
    parameter int            WFIFO_DEPTH  = 4,
    parameter int            STARVE_LIMIT = 64,
    parameter logic [DW-1:0] CLEAR_CHAR   = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          disp_req,
    input  logic [AW-1:0] disp_addr,
    output logic [DW-1:0] disp_data,
    output logic          disp_stall,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_valid,
    output logic          rd_ready,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          rd_dvalid,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic          ram_we,
    input  logic [DW-1:0] ram_dout,
    output logic          busy
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int CW = $clog2(WFIFO_DEPTH) + 1;

    grant_t               grant;
    logic                 in_clear;
    logic [AW-1:0]        clr_addr;
    logic [SW-1:0]        starve_cnt;
    logic                 starved;
    logic                 host_pending;
    logic                 fifo_push;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CW-1:0]        fifo_count;
    logic [AW+DW-1:0]     fifo_head;
    logic                 we_int;

`ifdef TEXT_RAM_CLEAR_EN
    state_t state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= CLEAR;
            clr_addr <= '0;
        end else if (state == CLEAR) begin
            clr_addr <= clr_addr + 1'b1;
            if (&clr_addr) state <= RUN;
        end
    end

    assign in_clear = (state == CLEAR);
`else
    assign in_clear = 1'b0;
    assign clr_addr = '0;
`endif

    assign fifo_push = wr_valid && !in_clear && !fifo_full;

    text_ram_wfifo #(
        .DEPTH (WFIFO_DEPTH),
        .W     (AW + DW)
    ) u_wfifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data ({wr_addr, wr_data}),
        .pop       (grant == G_WR),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign host_pending = !fifo_empty || rd_valid;
    assign starved      = (starve_cnt == SW'(STARVE_LIMIT));

    // Reads only win when the queue is empty, so a read never overtakes an earlier write.
    always_comb begin
        grant = G_NONE;
        if (in_clear)                    grant = G_CLR;
        else if (starved && host_pending) grant = fifo_empty ? G_RD : G_WR;
        else if (disp_req)               grant = G_DISP;
        else if (!fifo_empty)            grant = G_WR;
        else if (rd_valid)               grant = G_RD;
    end

    always_comb begin
        ram_addr = '0;
        ram_din  = '0;
        we_int   = 1'b0;
        case (grant)
            G_DISP:  ram_addr = disp_addr;
            G_WR: begin
                ram_addr = fifo_head[AW+DW-1:DW];
                ram_din  = fifo_head[DW-1:0];
                we_int   = 1'b1;
            end
            G_RD:    ram_addr = rd_addr;
            G_CLR: begin
                ram_addr = clr_addr;
                ram_din  = CLEAR_CHAR;
                we_int   = 1'b1;
            end
            default: ram_addr = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
            rd_dvalid  <= 1'b0;
        end else begin
            rd_dvalid <= rd_valid && (grant == G_RD);
            if (grant == G_WR || grant == G_RD || !host_pending) starve_cnt <= '0;
            else if (!starved)                                   starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Handshake outputs are held low while reset is asserted, independent of the FSM state.
    assign ram_we     = reset && we_int;
    assign wr_ready   = reset && !in_clear && !fifo_full;
    assign rd_ready   = reset && (grant == G_RD);
    assign disp_stall = reset && disp_req && (grant != G_DISP) && (grant != G_NONE);
    assign busy       = in_clear || (fifo_count != '0);
    assign disp_data  = ram_dout;
    assign rd_data    = ram_dout;
endmodule

// File: tb/tb_text_ram_arbiter.sv
// tb/tb_text_ram_arbiter.sv - self-checking bench for text_ram_arbiter with a ram_sync model
module tb_text_ram_arbiter;
    localparam int STARVE = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       disp_req = 1'b0;
    logic [9:0] disp_addr = '0;
    logic [7:0] disp_data;
    logic       disp_stall;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [9:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       rd_valid = 1'b0;
    logic       rd_ready;
    logic [9:0] rd_addr = '0;
    logic [7:0] rd_data;
    logic       rd_dvalid;
    logic [9:0] ram_addr;
    logic [7:0] ram_din;
    logic       ram_we;
    logic [7:0] ram_dout;
    logic       busy;

    logic [7:0]  mem     [1024] = '{default: 8'h00};
    logic [7:0]  ref_mem [1024] = '{default: 8'h00};
    logic [17:0] wq [$];
    int checks = 0;
    int errors = 0;

    text_ram_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .disp_req   (disp_req),
        .disp_addr  (disp_addr),
        .disp_data  (disp_data),
        .disp_stall (disp_stall),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_dvalid  (rd_dvalid),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_we     (ram_we),
        .ram_dout   (ram_dout),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // ram_sync: registered read, write on we
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    task automatic do_read(input logic [9:0] a, output logic [7:0] d, output logic ok);
        ok = 1'b0;
        d  = '0;
        @(posedge clk); #1;
        rd_valid = 1'b1;
        rd_addr  = a;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (rd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        rd_valid = 1'b0;
        @(negedge clk);
        if (ok) begin
            ok = rd_dvalid;
            d  = rd_data;
        end
    endtask

    task automatic test_reset();
        logic [7:0] d;
        logic       ok;
        logic [9:0] a;
        reset = 1'b0; disp_req = 1'b1; rd_valid = 1'b1; wr_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({ram_we, wr_ready, rd_ready, disp_stall, rd_dvalid} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_outputs: we/wrdy/rrdy/stall/dvalid=%b required 00000",
                     {ram_we, wr_ready, rd_ready, disp_stall, rd_dvalid});
        end
        @(posedge clk); #1;
        reset = 1'b1; rd_valid = 1'b0; wr_valid = 1'b0;
`ifdef TEXT_RAM_CLEAR_EN
        begin
            int bad;
            bad = 0;
            for (int i = 0; i < 1024; i++) begin
                @(negedge clk);
                if (ram_we !== 1'b1 || ram_addr !== 10'(i) || ram_din !== 8'h00 ||
                    disp_stall !== 1'b1 || wr_ready !== 1'b0 || busy !== 1'b1) bad++;
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL clear_sweep: %0d bad cycles required 0", bad);
            end
        end
`endif
        @(negedge clk);
        checks++;
        if (wr_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL after_reset: wr_ready=%b busy=%b required 1 0", wr_ready, busy);
        end
        disp_req = 1'b0;
        a = 10'($urandom_range(0, 1023));
        do_read(a, d, ok);
        checks++;
        if (!ok || d !== ref_mem[a]) begin
            errors++;
            $display("FAIL reset_readback: ok=%b data=%h required 1 %h", ok, d, ref_mem[a]);
        end
    endtask

    task automatic test_write_burst();
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            disp_req = 1'b0;
            wr_valid = (i < 4);
            wr_addr  = 10'(5 + i);
            wr_data  = 8'(8'hA0 + i);
            @(negedge clk);
            if (i < 4) begin
                checks++;
                if (wr_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL burst_accept[%0d]: wr_ready=%b required 1", i, wr_ready);
                end
                ref_mem[wr_addr] = wr_data;
            end
            checks++;
            if (i >= 1 && i <= 4) begin
                if (ram_we !== 1'b1 || ram_addr !== 10'(4 + i) || ram_din !== 8'(8'hA0 + i - 1)) begin
                    errors++;
                    $display("FAIL burst_write[%0d]: we=%b addr=%0d din=%h required 1 %0d %h",
                             i, ram_we, ram_addr, ram_din, 4 + i, 8'(8'hA0 + i - 1));
                end
            end else if (ram_we !== 1'b0) begin
                errors++;
                $display("FAIL burst_idle[%0d]: we=%b required 0", i, ram_we);
            end
        end
        wr_valid = 1'b0;
    endtask

    task automatic test_fifo_full();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            disp_req  = 1'b1;
            disp_addr = 10'($urandom_range(0, 1023));
            wr_valid  = 1'b1;
            wr_addr   = 10'(20 + i);
            wr_data   = 8'($urandom);
            @(negedge clk);
            checks++;
            if (wr_ready !== (i < 4) || ram_we !== 1'b0) begin
                errors++;
                $display("FAIL full_accept[%0d]: wr_ready=%b we=%b required %b 0", i, wr_ready, ram_we, (i < 4));
            end
            if (wr_valid && wr_ready) begin
                wq.push_back({wr_addr, wr_data});
                ref_mem[wr_addr] = wr_data;
            end
        end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            disp_req = 1'b0;
            wr_valid = 1'b0;
            @(negedge clk);
            if (ram_we) begin
                checks++;
                if (wq.size() == 0 || {ram_addr, ram_din} !== wq[0]) begin
                    errors++;
                    $display("FAIL full_drain: addr=%0d din=%h out of order", ram_addr, ram_din);
                end
                if (wq.size() != 0) void'(wq.pop_front());
            end
        end
        checks++;
        if (wq.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL full_empty: left=%0d busy=%b required 0 0", wq.size(), busy);
        end
    endtask

    task automatic test_raw();
        @(posedge clk); #1;
        disp_req = 1'b0; wr_valid = 1'b1; wr_addr = 10'd12; wr_data = 8'h3C;
        @(negedge clk);
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL raw_accept: wr_ready=%b required 1", wr_ready);
        end
        ref_mem[12] = 8'h3C;
        @(posedge clk); #1;
        wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 10'd12;
        @(negedge clk);
        checks++;
        if (rd_ready !== 1'b0 || ram_we !== 1'b1) begin
            errors++;
            $display("FAIL raw_hold: rd_ready=%b we=%b required 0 1", rd_ready, ram_we);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (rd_ready !== 1'b1 || rd_dvalid !== 1'b0) begin
            errors++;
            $display("FAIL raw_grant: rd_ready=%b rd_dvalid=%b required 1 0", rd_ready, rd_dvalid);
        end
        @(posedge clk); #1;
        rd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (rd_dvalid !== 1'b1 || rd_data !== 8'h3C) begin
            errors++;
            $display("FAIL raw_data: rd_dvalid=%b rd_data=%h required 1 3c", rd_dvalid, rd_data);
        end
    endtask

    task automatic test_starve();
        logic [9:0] a;
        logic [7:0] d;
        logic       want;
        a = 10'($urandom_range(200, 299));
        d = 8'($urandom);
        @(posedge clk); #1;
        disp_req = 1'b1; wr_valid = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL starve_accept: wr_ready=%b required 1", wr_ready);
        end
        ref_mem[a] = d;
        for (int k = 1; k <= STARVE + 6; k++) begin
            @(posedge clk); #1;
            wr_valid  = 1'b0;
            disp_addr = 10'($urandom_range(0, 1023));
            @(negedge clk);
            want = (k == STARVE + 1);
            checks++;
            if (ram_we !== want || disp_stall !== want) begin
                errors++;
                $display("FAIL starve[%0d]: we=%b stall=%b required %b %b", k, ram_we, disp_stall, want, want);
            end
            if (want) begin
                checks++;
                if (ram_addr !== a || ram_din !== d) begin
                    errors++;
                    $display("FAIL starve_slot: addr=%0d din=%h required %0d %h", ram_addr, ram_din, a, d);
                end
            end
        end
        disp_req = 1'b0;
    endtask

    task automatic test_toggle();
        logic       prev_disp;
        logic [7:0] exp_disp;
        prev_disp = 1'b0;
        exp_disp  = '0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            disp_req = 1'b1; wr_valid = 1'b1;
            wr_addr = 10'(30 + i); wr_data = 8'($urandom);
            @(negedge clk);
            checks++;
            if (wr_ready !== 1'b1 || ram_we !== 1'b0) begin
                errors++;
                $display("FAIL toggle_fill[%0d]: wr_ready=%b we=%b required 1 0", i, wr_ready, ram_we);
            end
            wq.push_back({wr_addr, wr_data});
            ref_mem[wr_addr] = wr_data;
        end
        for (int j = 0; j < 12; j++) begin
            @(posedge clk); #1;
            wr_valid  = 1'b0;
            disp_req  = (j % 2 == 0);
            disp_addr = 10'($urandom_range(28, 35));
            @(negedge clk);
            checks++;
            if (disp_stall !== 1'b0 || ram_we !== (!disp_req && wq.size() != 0)) begin
                errors++;
                $display("FAIL toggle[%0d]: stall=%b we=%b required 0 %b", j, disp_stall, ram_we,
                         (!disp_req && wq.size() != 0));
            end
            if (prev_disp) begin
                checks++;
                if (disp_data !== exp_disp) begin
                    errors++;
                    $display("FAIL toggle_disp[%0d]: disp_data=%h required %h", j, disp_data, exp_disp);
                end
            end
            if (ram_we && wq.size() != 0) begin
                checks++;
                if ({ram_addr, ram_din} !== wq[0]) begin
                    errors++;
                    $display("FAIL toggle_order[%0d]: addr=%0d din=%h required %0d %h",
                             j, ram_addr, ram_din, wq[0][17:8], wq[0][7:0]);
                end
                void'(wq.pop_front());
            end
            prev_disp = disp_req && !disp_stall;
            if (prev_disp) exp_disp = mem[disp_addr];
        end
        disp_req = 1'b0;
        checks++;
        if (wq.size() != 0) begin
            errors++;
            $display("FAIL toggle_drain: left=%0d required 0", wq.size());
        end
    endtask

    task automatic test_random();
        logic       prev_disp, prev_rd, last_xfer, tail;
        logic [7:0] exp_disp, exp_rd;
        int         pre;
        prev_disp = 1'b0; prev_rd = 1'b0; last_xfer = 1'b0;
        exp_disp = '0; exp_rd = '0;
        for (int c = 0; c < 500; c++) begin
            tail = (c >= 460);
            @(posedge clk); #1;
            disp_req  = !tail && ($urandom_range(0, 9) < 6);
            disp_addr = 10'($urandom_range(0, 15));
            wr_valid  = !tail && ($urandom_range(0, 2) == 0);
            wr_addr   = 10'($urandom_range(0, 15));
            wr_data   = 8'($urandom);
            if (!rd_valid || last_xfer) begin
                rd_valid = !tail && ($urandom_range(0, 5) == 0);
                rd_addr  = 10'($urandom_range(0, 15));
            end
            @(negedge clk);
            pre = wq.size();
            checks++;
            if (rd_dvalid !== prev_rd || (prev_rd && rd_data !== exp_rd)) begin
                errors++;
                $display("FAIL rand_read[%0d]: dvalid=%b data=%h required %b %h", c, rd_dvalid, rd_data, prev_rd, exp_rd);
            end
            if (prev_disp) begin
                checks++;
                if (disp_data !== exp_disp) begin
                    errors++;
                    $display("FAIL rand_disp[%0d]: disp_data=%h required %h", c, disp_data, exp_disp);
                end
            end
            checks++;
            if (wr_ready !== (pre < 4)) begin
                errors++;
                $display("FAIL rand_wr_ready[%0d]: wr_ready=%b required %b", c, wr_ready, (pre < 4));
            end
            checks++;
            if (rd_ready && pre != 0) begin
                errors++;
                $display("FAIL rand_raw[%0d]: rd_ready=1 with %0d writes queued required 0", c, pre);
            end
            checks++;
            if (ram_we && disp_req && !disp_stall) begin
                errors++;
                $display("FAIL rand_prio[%0d]: we=1 during display grant required 0", c);
            end
            if (ram_we) begin
                checks++;
                if (pre == 0 || {ram_addr, ram_din} !== wq[0]) begin
                    errors++;
                    $display("FAIL rand_order[%0d]: addr=%0d din=%h queued=%0d", c, ram_addr, ram_din, pre);
                end
                if (pre != 0) void'(wq.pop_front());
            end
            last_xfer = rd_valid && rd_ready;
            prev_rd   = last_xfer;
            if (last_xfer) exp_rd = ref_mem[rd_addr];
            prev_disp = disp_req && !disp_stall;
            if (prev_disp) exp_disp = mem[disp_addr];
            if (wr_valid && wr_ready) begin
                wq.push_back({wr_addr, wr_data});
                ref_mem[wr_addr] = wr_data;
            end
        end
        @(posedge clk); #1;
        rd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (wq.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rand_final: left=%0d busy=%b required 0 0", wq.size(), busy);
        end
    endtask

    task automatic test_reset_mid_drain();
        logic [7:0] d;
        logic       ok;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            disp_req = 1'b1; wr_valid = 1'b1;
            wr_addr = 10'(100 + i); wr_data = (i == 0) ? 8'h5A : 8'hC3;
            @(negedge clk);
        end
        @(posedge clk); #1;
        wr_valid = 1'b0;
        reset    = 1'b0;
        @(negedge clk);
        checks++;
        if ({ram_we, rd_dvalid, wr_ready, disp_stall} !== 4'b0000) begin
            errors++;
            $display("FAIL midreset_outputs: we/dvalid/wrdy/stall=%b required 0000",
                     {ram_we, rd_dvalid, wr_ready, disp_stall});
        end
        @(posedge clk); #1;
        reset    = 1'b1;
        disp_req = 1'b0;
`ifdef TEXT_RAM_CLEAR_EN
        repeat (1024) @(posedge clk);
        #1;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
`endif
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (ram_we !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL midreset_idle[%0d]: we=%b busy=%b required 0 0", i, ram_we, busy);
            end
        end
        for (int i = 0; i < 2; i++) begin
            do_read(10'(100 + i), d, ok);
            checks++;
            if (!ok || d !== ref_mem[100 + i]) begin
                errors++;
                $display("FAIL midreset_ram[%0d]: ok=%b data=%h required 1 %h", 100 + i, ok, d, ref_mem[100 + i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_fifo_full();
        test_raw();
        test_starve();
        test_toggle();
        test_random();
        test_reset_mid_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
